// File: rtl/huffman_encode_arbiter_if.sv
// Handshake bundle between the per-channel code FIFOs, the arbiter and the
// shared huffman_encode code/rdy/pop port.
//   master : arbiter side (reads FIFO heads and encoder pop, drives pops/code/rdy)
//   slave  : FIFO + encoder side
interface huffman_encode_arbiter_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH*4-1:0] ch_code;
   logic [NUM_CH-1:0]   ch_rdy;
   logic [NUM_CH-1:0]   ch_pop;
   logic [3:0]          enc_code;
   logic                enc_rdy;
   logic                enc_pop;

   modport master (
      input  ch_code,
      input  ch_rdy,
      input  enc_pop,
      output ch_pop,
      output enc_code,
      output enc_rdy
   );

   modport slave (
      output ch_code,
      output ch_rdy,
      output enc_pop,
      input  ch_pop,
      input  enc_code,
      input  enc_rdy
   );
endinterface

// File: rtl/huffman_encode_arbiter.sv
// huffman_encode_arbiter
// Shares one huffman_encode code/rdy/pop port among NUM_CH FWFT code FIFOs.
// A channel keeps the grant from its first code through its EOM code, so
// messages never interleave. Arbitration is round-robin; the channel that
// just finished has the lowest priority next time.
// Optional macro HUFF_ARB_WATCHDOG_EN: a stall watchdog that, after WD_LIMIT
// empty cycles of the granted channel, feeds a synthetic EOM to the encoder
// and pulses wd_err. Without the macro wd_err is tied low.
module huffman_encode_arbiter #(
   parameter int         NUM_CH   = 4,
   parameter int         CH_W     = 2,
   parameter logic [3:0] EOM_CODE = 4'd8,
   parameter int         WD_LIMIT = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   huffman_encode_arbiter_if.master   bus,
   output logic                       grant_vld,
   output logic [CH_W-1:0]            grant_ch,
   output logic                       msg_done,
   output logic                       wd_err
);

   // Elaboration-time parameter sanity check
   if (NUM_CH < 1 || NUM_CH > 8 || (1 << CH_W) < NUM_CH || WD_LIMIT < 1) begin : g_param_chk
      $error("huffman_encode_arbiter: illegal NUM_CH/CH_W/WD_LIMIT combination");
   end

`ifdef HUFF_ARB_WATCHDOG_EN
   typedef enum logic [1:0] {IDLE, LOCK, RELEASE, FLUSH} state_t;
   localparam int WD_W = $clog2(WD_LIMIT + 1);
`else
   typedef enum logic [1:0] {IDLE, LOCK, RELEASE} state_t;
`endif

   state_t            state_q,     state_d;
   logic              grant_vld_q, grant_vld_d;
   logic [CH_W-1:0]   grant_ch_q,  grant_ch_d;
   logic [CH_W-1:0]   last_ch_q,   last_ch_d;
   logic              msg_done_q,  msg_done_d;
`ifdef HUFF_ARB_WATCHDOG_EN
   logic              wd_err_q,    wd_err_d;
   logic [WD_W-1:0]   stall_cnt_q, stall_cnt_d;
`endif

   // Granted channel's FIFO head, and the round-robin winner
   logic [3:0]        head_code;
   logic              head_rdy;
   logic              pick_vld;
   logic [CH_W-1:0]   pick_ch;
   int unsigned       rr_base;
   int unsigned       rr_idx;

   // Select the granted channel's head-of-FIFO code and not-empty flag
   always_comb begin
      head_code = '0;
      head_rdy  = 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (grant_ch_q == CH_W'(k)) begin
            head_code = bus.ch_code[4*k +: 4];
            head_rdy  = bus.ch_rdy[k];
         end
      end
   end

   // Round-robin search starting one past the last finished channel
   always_comb begin
      pick_vld = 1'b0;
      pick_ch  = '0;
      rr_base  = 32'(last_ch_q);
      rr_idx   = 0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         rr_idx = (rr_base + i) % NUM_CH;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!pick_vld && k == rr_idx && bus.ch_rdy[k]) begin
               pick_vld = 1'b1;
               pick_ch  = CH_W'(k);
            end
         end
      end
   end

   // Encoder-facing mux: pass-through of the granted channel while locked
   always_comb begin
      bus.enc_code = '0;
      bus.enc_rdy  = 1'b0;
      bus.ch_pop   = '0;
      case (state_q)
         LOCK: begin
            bus.enc_code = head_code;
            bus.enc_rdy  = head_rdy;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
               if (grant_ch_q == CH_W'(k)) begin
                  bus.ch_pop[k] = bus.enc_pop;
               end
            end
         end
`ifdef HUFF_ARB_WATCHDOG_EN
         FLUSH: begin
            bus.enc_code = EOM_CODE;
            bus.enc_rdy  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Next-state logic for the grant FSM and its registered status outputs
   always_comb begin
      state_d     = state_q;
      grant_vld_d = grant_vld_q;
      grant_ch_d  = grant_ch_q;
      last_ch_d   = last_ch_q;
      msg_done_d  = 1'b0;
`ifdef HUFF_ARB_WATCHDOG_EN
      wd_err_d    = 1'b0;
      stall_cnt_d = stall_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_ch_d  = pick_ch;
               grant_vld_d = 1'b1;
               state_d     = LOCK;
`ifdef HUFF_ARB_WATCHDOG_EN
               stall_cnt_d = '0;
`endif
            end
         end
         LOCK: begin
            if (bus.enc_pop && head_code == EOM_CODE) begin
               msg_done_d  = 1'b1;
               last_ch_d   = grant_ch_q;
               grant_vld_d = 1'b0;
               state_d     = RELEASE;
            end
`ifdef HUFF_ARB_WATCHDOG_EN
            // Stall counter only advances while the granted FIFO is empty
            else if (bus.enc_pop || head_rdy) begin
               stall_cnt_d = '0;
            end else if (stall_cnt_q == WD_W'(WD_LIMIT - 1)) begin
               stall_cnt_d = '0;
               state_d     = FLUSH;
            end else begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
`endif
         end
         RELEASE: begin
            grant_vld_d = 1'b0;
            state_d     = IDLE;
         end
`ifdef HUFF_ARB_WATCHDOG_EN
         FLUSH: begin
            if (bus.enc_pop) begin
               wd_err_d    = 1'b1;
               msg_done_d  = 1'b1;
               last_ch_d   = grant_ch_q;
               grant_vld_d = 1'b0;
               state_d     = RELEASE;
            end
         end
`endif
         default: begin
            grant_vld_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and status registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         grant_vld_q <= 1'b0;
         grant_ch_q  <= '0;
         last_ch_q   <= CH_W'(NUM_CH - 1);
         msg_done_q  <= 1'b0;
`ifdef HUFF_ARB_WATCHDOG_EN
         wd_err_q    <= 1'b0;
         stall_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_vld_q <= grant_vld_d;
         grant_ch_q  <= grant_ch_d;
         last_ch_q   <= last_ch_d;
         msg_done_q  <= msg_done_d;
`ifdef HUFF_ARB_WATCHDOG_EN
         wd_err_q    <= wd_err_d;
         stall_cnt_q <= stall_cnt_d;
`endif
      end
   end

   assign grant_vld = grant_vld_q;
   assign grant_ch  = grant_ch_q;
   assign msg_done  = msg_done_q;
`ifdef HUFF_ARB_WATCHDOG_EN
   assign wd_err    = wd_err_q;
`else
   assign wd_err    = 1'b0;
`endif

endmodule
